// File: rtl/spi_bus_arbiter.sv
// Shares one chameleon2_spi byte master between several SPI clients, one chip-select transaction at a time.
// Optional owner-idle watchdog: define SPI_ARB_TIMEOUT_EN.
module spi_bus_arbiter #(
    parameter int clients        = 3,
    parameter int guard_cycles   = 4,
    parameter int timeout_cycles = 1000000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [clients-1:0]     c_cs_n,
    input  logic [clients-1:0]     c_req,
    output logic [clients-1:0]     c_ack,
    input  logic [8*clients-1:0]   c_d,
    input  logic [clients-1:0]     c_speed,
    output logic [7:0]             c_q,
    output logic [clients-1:0]     c_grant,
    output logic [clients-1:0]     cs_n_out,
    output logic                   spi_req,
    input  logic                   spi_ack,
    output logic [7:0]             spi_d,
    input  logic [7:0]             spi_q,
    output logic                   spi_speed,
    output logic                   timeout
);

    localparam int IDX_W = (clients > 1) ? $clog2(clients) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_OWNED,
        S_XFER,
        S_GUARD
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;
    logic [IDX_W-1:0]     r_owner;
    logic [IDX_W-1:0]     r_ptr;
    logic [7:0]           r_guard_cnt;
    logic [clients-1:0]   r_grant;
    logic [clients-1:0]   r_cs_n;
    logic [clients-1:0]   r_ack;
    logic [7:0]           r_q;
    logic                 r_spi_req;
    logic [7:0]           r_spi_d;
    logic                 r_spi_speed;
    logic                 r_timeout;

    logic [IDX_W:0]       w_pick;
    logic                 w_hit;
    logic [IDX_W-1:0]     w_hit_idx;
    logic [clients-1:0]   w_onehot;
    logic                 w_owner_cs_n;
    logic                 w_owner_pend;
    logic [7:0]           w_owner_d;
    logic [IDX_W-1:0]     w_next_ptr;
    logic                 w_take;
    logic                 w_issue;
    logic                 w_done;
    logic                 w_release;
    logic                 w_to_fire;
    logic                 w_to_hit;

    // First requester at or after ptr, wrapping; MSB of the result flags a hit.
    function automatic logic [IDX_W:0] rr_pick(input logic [clients-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
        logic [IDX_W:0] res;
        int             cand;
        res = '0;
        for (int i = clients - 1; i >= 0; i--) begin
            cand = int'(ptr) + i;
            if (cand >= clients) cand = cand - clients;
            if (req[cand]) res = {1'b1, cand[IDX_W-1:0]};
        end
        return res;
    endfunction

    assign w_pick       = rr_pick(~c_cs_n, r_ptr);
    assign w_hit        = w_pick[IDX_W];
    assign w_hit_idx    = w_pick[IDX_W-1:0];
    assign w_onehot     = clients'(1) << w_hit_idx;
    assign w_owner_cs_n = c_cs_n[r_owner];
    assign w_owner_pend = c_req[r_owner] ^ r_ack[r_owner];
    assign w_owner_d    = c_d[{r_owner, 3'b000} +: 8];
    assign w_next_ptr   = (r_owner == IDX_W'(clients - 1)) ? '0 : r_owner + 1'b1;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(timeout_cycles + 1);
    logic [TO_W-1:0] r_to_cnt;

    assign w_to_hit = (r_to_cnt == TO_W'(timeout_cycles - 1));

    // Counts idle cycles of the owner; any issued byte restarts the window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt <= '0;
        end else if (r_state == S_OWNED && !w_issue) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end else begin
            r_to_cnt <= '0;
        end
    end
`else
    assign w_to_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_take     = 1'b0;
        w_issue    = 1'b0;
        w_done     = 1'b0;
        w_release  = 1'b0;
        w_to_fire  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_hit) begin
                    w_take     = 1'b1;
                    w_state_nx = S_OWNED;
                end
            end
            S_OWNED: begin
                if (w_owner_cs_n) begin
                    w_release  = 1'b1;
                    w_state_nx = S_GUARD;
                end else if (w_owner_pend) begin
                    w_issue    = 1'b1;
                    w_state_nx = S_XFER;
                end else if (w_to_hit) begin
                    w_release  = 1'b1;
                    w_to_fire  = 1'b1;
                    w_state_nx = S_GUARD;
                end
            end
            // CS stays asserted until the byte finishes, even if the owner lets go.
            S_XFER: begin
                if (spi_ack == r_spi_req) begin
                    w_done     = 1'b1;
                    w_state_nx = S_OWNED;
                end
            end
            S_GUARD: begin
                if (r_guard_cnt == 8'd0) w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_owner     <= '0;
            r_ptr       <= '0;
            r_guard_cnt <= '0;
            r_grant     <= '0;
            r_cs_n      <= '1;
            r_ack       <= '0;
            r_q         <= '0;
            r_spi_req   <= 1'b0;
            r_spi_d     <= '0;
            r_spi_speed <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_timeout <= w_to_fire;
            if (w_take) begin
                r_owner     <= w_hit_idx;
                r_grant     <= w_onehot;
                r_cs_n      <= ~w_onehot;
                r_spi_speed <= c_speed[w_hit_idx];
            end
            if (w_issue) begin
                r_spi_d   <= w_owner_d;
                r_spi_req <= ~r_spi_req;
            end
            if (w_done) begin
                r_q            <= spi_q;
                r_ack[r_owner] <= c_req[r_owner];
            end
            if (w_release) begin
                r_grant     <= '0;
                r_cs_n      <= '1;
                r_ptr       <= w_next_ptr;
                r_guard_cnt <= 8'(guard_cycles - 1);
            end else if (r_state == S_GUARD && r_guard_cnt != 8'd0) begin
                r_guard_cnt <= r_guard_cnt - 8'd1;
            end
        end
    end

    assign c_ack     = r_ack;
    assign c_q       = r_q;
    assign c_grant   = r_grant;
    assign cs_n_out  = r_cs_n;
    assign spi_req   = r_spi_req;
    assign spi_d     = r_spi_d;
    assign spi_speed = r_spi_speed;
    assign timeout   = r_timeout;

endmodule
